htiming_gen: RTL and testbench
==============================

# htiming_gen

Parametrised horizontal timing generator for the VGA driver; next generation of the fixed 1600-cycle line generator. Produces the horizontal sync pulse, the active-video window, a pixel index with configurable clocks-per-pixel, and per-pixel and per-line strobes. The counters advance only on an enable input, so one block serves several pixel clocks from a single system clock. It feeds the vertical timing block and the RGB output stage.

## Interface

- SYNC, 192: sync pulse width in cycles.
- BPORCH, 96: back porch width in cycles.
- ACTIVE, 1280: active video width in cycles; must be a multiple of DIV.
- FPORCH, 32: front porch width in cycles.
- DIV, 5: enabled cycles per pixel, ≥1.
- PIX_W, 8: hpixel width; must be ≥ clog2(ACTIVE/DIV).
- SYNC_POL, 0: hsync level while asserted; 0 means active-low.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ce  in  1  advance enable; counters hold while 0.
- hsync  out  1  sync output, registered.
- active  out  1  high during the active window, registered.
- hpixel  out  PIX_W  pixel index in active window, 0 in blanking, registered.
- pix_stb  out  1  first enabled cycle of each pixel, registered.
- line_end  out  1  last enabled cycle of the line, registered.
- line_start  out  1  first enabled cycle of the line; only with HTIMING_LINE_STROBE_EN.

## Operation

- TOTAL = SYNC+BPORCH+ACTIVE+FPORCH. Internal phase counter hcnt has width clog2(TOTAL) and runs 0..TOTAL-1, then wraps to 0.
- Sub-pixel counter dcnt runs 0..DIV-1 only inside the active window. It is forced to 0 outside the window.
- Phases in hcnt order:
  - SYNC: hcnt 0..SYNC-1.
  - BACK: hcnt SYNC..SYNC+BPORCH-1.
  - VIDEO: hcnt A0=SYNC+BPORCH .. A0+ACTIVE-1.
  - FRONT: remaining counts to TOTAL-1. FRONT wraps to SYNC.
- Outputs describe the current hcnt. They are registered from the next-state decode, so there is no pipeline offset between hcnt and the outputs.
  - hsync = SYNC_POL in the SYNC phase, ~SYNC_POL otherwise.
  - active = 1 only in the VIDEO phase.
  - hpixel = (hcnt−A0)/DIV in the VIDEO phase, 0 otherwise. It restarts at 0 on every line and never wraps mid-line.
  - pix_stb = ce & active & (dcnt==0).
  - line_end = ce & (hcnt==TOTAL−1).
  - line_start = ce & (hcnt==0).
- ce=0: hcnt, dcnt, hsync, active and hpixel hold their values. pix_stb, line_end and line_start are 0.
- Reset (any cycle, including mid-line):
  - hcnt=0, dcnt=0.
  - hsync=SYNC_POL, active=0, hpixel=0.
  - pix_stb=0, line_end=0, line_start=0.
- Reset has priority over ce.

## Timing

- First rising edge with reset high: all outputs take their reset values at that edge.
- First edge with reset low and ce=1: hcnt moves 0→1. The first line therefore starts with a SYNC phase of full SYNC length, counting the reset cycle as hcnt=0.
- Line period = TOTAL enabled cycles.
  - With ce held high and default parameters: 1600 clk cycles.
  - hsync is asserted for the first 192 cycles of the line.
  - active is high on cycles 288..1567 of the line.
- Each hpixel value is held for exactly DIV enabled cycles; pix_stb fires on the first of them.
- line_end and the wrap to hcnt=0 happen on consecutive enabled cycles; line_start coincides with hcnt=0.
- Degenerate parameters:
  - BPORCH=0 or FPORCH=0: the corresponding phase is skipped with no extra cycle.
  - DIV=1: pix_stb is high on every enabled active cycle.

## Configuration

- Macro HTIMING_LINE_STROBE_EN.
- Defined: the line_start port exists and is driven as specified above.
- Undefined: the line_start port and its logic are absent; all other behaviour is identical.

## Test plan

- Reset values: hold reset 3 cycles, ce=1 → hsync=0, active=0, hpixel=0, pix_stb=0, line_end=0 on every reset cycle.
- Default full line, ce=1:
  - Per 1600-cycle line: hsync low 192 cycles, active high cycles 288..1567.
  - 256 pix_stb pulses, 5 cycles apart, with hpixel 0..255.
  - One line_end at cycle 1599; hpixel=0 again on the next line.
- ce toggling 1,0,1,0…: line period 3200 clk cycles; outputs stable on ce=0 cycles; strobes never high on ce=0 cycles; 256 pix_stb per line.
- Reset mid-line at hcnt=700 (hpixel=82): the next cycle shows reset values, and the following line timing matches a fresh start.
- Small configuration SYNC=2, BPORCH=0, ACTIVE=6, FPORCH=1, DIV=3, SYNC_POL=1:
  - Line period 9 cycles; hsync=1 on cycles 0-1.
  - active on cycles 2-7; hpixel 0,0,0,1,1,1.
  - pix_stb on cycles 2 and 5; line_end on cycle 8.
- HTIMING_LINE_STROBE_EN defined, default parameters: line_start is 1 exactly on each hcnt=0 enabled cycle, i.e. once per 1600 cycles. It is 0 during reset.

Source files
------------

// File: rtl/htiming_gen.sv
// -----------------------------------------------------------------------------
// htiming_gen
//
// Parametrised horizontal timing generator for the VGA driver. A phase counter
// walks one video line (sync, back porch, active video, front porch) and
// advances only on enabled cycles, so a single system clock can serve several
// pixel clocks. It produces the sync pulse, the active-video window, a pixel
// index with DIV enabled cycles per pixel, and per-pixel / per-line strobes.
//
// Optional feature macro: HTIMING_LINE_STROBE_EN
//   defined   -> line_start port exists (first enabled cycle of each line)
//   undefined -> line_start port and logic are absent
//
// Parameters:
//   SYNC     sync pulse width (cycles, >= 1)
//   BPORCH   back porch width (cycles, may be 0)
//   ACTIVE   active video width (cycles, multiple of DIV)
//   FPORCH   front porch width (cycles, may be 0)
//   DIV      enabled cycles per pixel (>= 1)
//   PIX_W    hpixel width (>= clog2(ACTIVE/DIV))
//   SYNC_POL hsync level while asserted (0 = active-low)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset, priority over ce
//   ce         in   advance enable; counters and levels hold while low
//   hsync      out  sync output (registered)
//   active     out  high in the active-video window (registered)
//   hpixel     out  pixel index inside the window, 0 in blanking (registered)
//   pix_stb    out  first enabled cycle of each pixel (registered)
//   line_end   out  last enabled cycle of the line (registered)
//   line_start out  first enabled cycle of the line (registered, optional)
//
// All outputs are decoded from the next-state values and registered together
// with the counters, so they always describe the current phase count with no
// pipeline offset. A cycle counts as "enabled" when the edge that started it
// sampled ce high; strobes are therefore zero in cycles entered with ce low.
// -----------------------------------------------------------------------------
module htiming_gen #(
  parameter int unsigned SYNC     = 192,
  parameter int unsigned BPORCH   = 96,
  parameter int unsigned ACTIVE   = 1280,
  parameter int unsigned FPORCH   = 32,
  parameter int unsigned DIV      = 5,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic             hsync,
  output logic             active,
  output logic [PIX_W-1:0] hpixel,
  output logic             pix_stb,
  output logic             line_end
`ifdef HTIMING_LINE_STROBE_EN
  ,
  output logic             line_start
`endif
);

  localparam int unsigned TOTAL  = SYNC + BPORCH + ACTIVE + FPORCH;
  localparam int unsigned A0     = SYNC + BPORCH;
  localparam int unsigned HCNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned DCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Last count of each phase. With BPORCH=0 BACK_LAST equals SYNC_LAST and
  // the back-porch phase is never entered; likewise FPORCH=0 makes
  // VIDEO_LAST the last count of the line.
  localparam logic [HCNT_W-1:0] SYNC_LAST  = HCNT_W'(SYNC - 1);
  localparam logic [HCNT_W-1:0] BACK_LAST  = HCNT_W'(A0 - 1);
  localparam logic [HCNT_W-1:0] VIDEO_LAST = HCNT_W'(A0 + ACTIVE - 1);
  localparam logic [HCNT_W-1:0] LINE_LAST  = HCNT_W'(TOTAL - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DIV - 1);
  localparam logic              SYNC_LVL   = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_BACK,
    PH_VIDEO,
    PH_FRONT
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [PIX_W-1:0]   hpixel_q, hpixel_d;
  logic               hsync_q, hsync_d;
  logic               active_q, active_d;
  logic               pix_stb_q, pix_stb_d;
  logic               line_end_q, line_end_d;
`ifdef HTIMING_LINE_STROBE_EN
  logic               line_start_q, line_start_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_SYNC;
      hcnt_q       <= '0;
      dcnt_q       <= '0;
      hpixel_q     <= '0;
      hsync_q      <= SYNC_LVL;
      active_q     <= 1'b0;
      pix_stb_q    <= 1'b0;
      line_end_q   <= 1'b0;
`ifdef HTIMING_LINE_STROBE_EN
      line_start_q <= 1'b0;
`endif
    end else begin
      phase_q      <= phase_d;
      hcnt_q       <= hcnt_d;
      dcnt_q       <= dcnt_d;
      hpixel_q     <= hpixel_d;
      hsync_q      <= hsync_d;
      active_q     <= active_d;
      pix_stb_q    <= pix_stb_d;
      line_end_q   <= line_end_d;
`ifdef HTIMING_LINE_STROBE_EN
      line_start_q <= line_start_d;
`endif
    end
  end

  always_comb begin
    phase_d      = phase_q;
    hcnt_d       = hcnt_q;
    dcnt_d       = dcnt_q;
    hpixel_d     = hpixel_q;
    hsync_d      = hsync_q;
    active_d     = active_q;
    pix_stb_d    = 1'b0;
    line_end_d   = 1'b0;
`ifdef HTIMING_LINE_STROBE_EN
    line_start_d = 1'b0;
`endif

    if (ce) begin
      hcnt_d = (hcnt_q == LINE_LAST) ? '0 : hcnt_q + 1'b1;

      unique case (phase_q)
        PH_SYNC:  if (hcnt_q == SYNC_LAST)  phase_d = (BPORCH != 0) ? PH_BACK : PH_VIDEO;
        PH_BACK:  if (hcnt_q == BACK_LAST)  phase_d = PH_VIDEO;
        PH_VIDEO: if (hcnt_q == VIDEO_LAST) phase_d = (FPORCH != 0) ? PH_FRONT : PH_SYNC;
        PH_FRONT: if (hcnt_q == LINE_LAST)  phase_d = PH_SYNC;
        default:  phase_d = PH_SYNC;
      endcase

      // Sub-pixel and pixel counters only run while staying inside the
      // window; entering or leaving it restarts both at 0, so hpixel never
      // wraps mid-line.
      if (phase_d == PH_VIDEO && phase_q == PH_VIDEO) begin
        if (dcnt_q == DCNT_LAST) begin
          dcnt_d   = '0;
          hpixel_d = hpixel_q + 1'b1;
        end else begin
          dcnt_d   = dcnt_q + 1'b1;
        end
      end else begin
        dcnt_d   = '0;
        hpixel_d = '0;
      end

      hsync_d      = (phase_d == PH_SYNC) ? SYNC_LVL : ~SYNC_LVL;
      active_d     = (phase_d == PH_VIDEO);
      pix_stb_d    = (phase_d == PH_VIDEO) && (dcnt_d == '0);
      line_end_d   = (hcnt_d == LINE_LAST);
`ifdef HTIMING_LINE_STROBE_EN
      line_start_d = (hcnt_d == '0);
`endif
    end
  end

  assign hsync      = hsync_q;
  assign active     = active_q;
  assign hpixel     = hpixel_q;
  assign pix_stb    = pix_stb_q;
  assign line_end   = line_end_q;
`ifdef HTIMING_LINE_STROBE_EN
  assign line_start = line_start_q;
`endif

endmodule

// File: tb/tb_htiming_gen.sv
// -----------------------------------------------------------------------------
// tb_htiming_gen
//
// Bench for htiming_gen. Two instances share clk/reset/ce: one with default
// parameters and one small configuration (SYNC=2, BPORCH=0, ACTIVE=6,
// FPORCH=1, DIV=3, SYNC_POL=1). A reference model tracks only the line
// position of each instance and derives every output from it arithmetically.
// Honours HTIMING_LINE_STROBE_EN for the optional line_start port.
// -----------------------------------------------------------------------------
module tb_htiming_gen;

  localparam int D_SYNC = 192, D_BP = 96, D_ACT = 1280, D_FP = 32, D_DIV = 5;
  localparam int D_TOTAL = D_SYNC + D_BP + D_ACT + D_FP;
  localparam int S_SYNC = 2, S_BP = 0, S_ACT = 6, S_FP = 1, S_DIV = 3;
  localparam int S_TOTAL = S_SYNC + S_BP + S_ACT + S_FP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce;

  logic       d_hsync, d_active, d_pix_stb, d_line_end;
  logic [7:0] d_hpixel;
  logic       s_hsync, s_active, s_pix_stb, s_line_end;
  logic [3:0] s_hpixel;
`ifdef HTIMING_LINE_STROBE_EN
  logic       d_line_start, s_line_start;
`endif

  htiming_gen u_def (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .hsync      (d_hsync),
    .active     (d_active),
    .hpixel     (d_hpixel),
    .pix_stb    (d_pix_stb),
    .line_end   (d_line_end)
`ifdef HTIMING_LINE_STROBE_EN
    ,
    .line_start (d_line_start)
`endif
  );

  htiming_gen #(
    .SYNC     (S_SYNC),
    .BPORCH   (S_BP),
    .ACTIVE   (S_ACT),
    .FPORCH   (S_FP),
    .DIV      (S_DIV),
    .PIX_W    (4),
    .SYNC_POL (1)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .hsync      (s_hsync),
    .active     (s_active),
    .hpixel     (s_hpixel),
    .pix_stb    (s_pix_stb),
    .line_end   (s_line_end)
`ifdef HTIMING_LINE_STROBE_EN
    ,
    .line_start (s_line_start)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        hsync;
    logic        active;
    logic [31:0] hpixel;
    logic        pix_stb;
    logic        line_end;
    logic        line_start;
  } exp_t;

  // Expected outputs for a given line position; adv says whether the edge
  // that entered this cycle advanced the line.
  function automatic exp_t ref_out(input int pos, input bit adv, input int sync,
                                   input int bp, input int act, input int div,
                                   input int total, input bit pol);
    exp_t e;
    int a0;
    a0           = sync + bp;
    e.hsync      = (pos < sync) ? pol : ~pol;
    e.active     = (pos >= a0) && (pos < a0 + act);
    e.hpixel     = e.active ? (pos - a0) / div : 0;
    e.pix_stb    = adv && e.active && (((pos - a0) % div) == 0);
    e.line_end   = adv && (pos == total - 1);
    e.line_start = adv && (pos == 0);
    return e;
  endfunction

  int d_pos = 0, s_pos = 0;
  bit adv = 0;
  int d_pix_cnt = 0, s_pix_cnt = 0;

  task automatic tick(input bit r, input bit c);
    exp_t de, se;
    reset = r;
    ce    = c;
    @(posedge clk);
    if (r) begin
      d_pos = 0;
      s_pos = 0;
      adv   = 0;
    end else if (c) begin
      d_pos = (d_pos + 1) % D_TOTAL;
      s_pos = (s_pos + 1) % S_TOTAL;
      adv   = 1;
    end else begin
      adv   = 0;
    end
    #1;
    de = ref_out(d_pos, adv, D_SYNC, D_BP, D_ACT, D_DIV, D_TOTAL, 1'b0);
    se = ref_out(s_pos, adv, S_SYNC, S_BP, S_ACT, S_DIV, S_TOTAL, 1'b1);
    check_eq("d_hsync",    d_hsync,    de.hsync);
    check_eq("d_active",   d_active,   de.active);
    check_eq("d_hpixel",   d_hpixel,   de.hpixel);
    check_eq("d_pix_stb",  d_pix_stb,  de.pix_stb);
    check_eq("d_line_end", d_line_end, de.line_end);
    check_eq("s_hsync",    s_hsync,    se.hsync);
    check_eq("s_active",   s_active,   se.active);
    check_eq("s_hpixel",   s_hpixel,   se.hpixel);
    check_eq("s_pix_stb",  s_pix_stb,  se.pix_stb);
    check_eq("s_line_end", s_line_end, se.line_end);
`ifdef HTIMING_LINE_STROBE_EN
    check_eq("d_line_start", d_line_start, de.line_start);
    check_eq("s_line_start", s_line_start, se.line_start);
`endif
    // Pixel strobes per complete line, counted from the DUT outputs.
    if (r) begin
      d_pix_cnt = 0;
      s_pix_cnt = 0;
    end else begin
      if (d_pix_stb) d_pix_cnt++;
      if (s_pix_stb) s_pix_cnt++;
      if (d_line_end) begin
        check_eq("d_pix_per_line", d_pix_cnt, D_ACT / D_DIV);
        d_pix_cnt = 0;
      end
      if (s_line_end) begin
        check_eq("s_pix_per_line", s_pix_cnt, S_ACT / S_DIV);
        s_pix_cnt = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;

    // Reset held for three cycles with ce high.
    repeat (3) tick(1'b1, 1'b1);

    // Two full lines with ce held high.
    repeat (2 * D_TOTAL) tick(1'b0, 1'b1);

    // ce toggling 1,0,... for two lines.
    for (int i = 0; i < 4 * D_TOTAL; i++) tick(1'b0, (i % 2) == 0);

    // Run to line position 700, then reset mid-line.
    for (int g = 0; g < 2 * D_TOTAL && d_pos != 700; g++) tick(1'b0, 1'b1);
    check_eq("d_hpixel_at_700", d_hpixel, 82);
    tick(1'b1, 1'b1);
    repeat (D_TOTAL + 100) tick(1'b0, 1'b1);

    // Random ce with rare resets.
    for (int i = 0; i < 8000; i++)
      tick(($urandom % 1500) == 0, ($urandom % 4) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
